// File: rtl/moving_average_pow2_if.sv
// moving_average_pow2_if: sample stream in, rounded mean and status out
interface moving_average_pow2_if #(
    parameter int DATA_WIDTH   = 16,
    parameter int LOG2_MAX_LEN = 6
);
    localparam int LW = $clog2(LOG2_MAX_LEN + 1);
    logic signed [DATA_WIDTH-1:0] Input;
    logic                         InValid;
    logic [LW-1:0]                Log2Len;
    logic signed [DATA_WIDTH-1:0] Output;
    logic                         OutValid;
    logic                         Settled;
    modport master (output Input, InValid, Log2Len, input Output, OutValid, Settled);
    modport slave (input Input, InValid, Log2Len, output Output, OutValid, Settled);
endinterface

// File: rtl/moving_average_pow2.sv
// moving_average_pow2: boxcar running mean over a run-time power-of-two window
module moving_average_pow2 #(
    parameter int LOG2_MAX_LEN = 6,
    parameter int DATA_WIDTH   = 16
) (
    input logic                  Clk,
    input logic                  Reset_n,
    moving_average_pow2_if.slave bus
);
    localparam int LW    = $clog2(LOG2_MAX_LEN + 1);
    localparam int DEPTH = 1 << LOG2_MAX_LEN;
    localparam int SW    = DATA_WIDTH + LOG2_MAX_LEN;
    localparam int FW    = LOG2_MAX_LEN + 1;

    logic signed [DATA_WIDTH-1:0] mem [DEPTH];
    logic [LOG2_MAX_LEN-1:0]      wr, rd;
    logic [FW-1:0]                fill, fill_next, n;
    logic [LW-1:0]                len_in, len_q;
    logic                         change, accept;
    logic signed [DATA_WIDTH-1:0] s1_new, s1_old;
    logic                         s1_sub, s1_full, s1_v;
    logic signed [SW-1:0]         sum;
    logic                         s2_full, s2_v;
    logic [SW:0]                  half;
    logic signed [SW:0]           rnd;

    // Length clamp/compare, read address of the oldest sample and the rounded sum
    always_comb begin
        len_in    = (bus.Log2Len > LW'(LOG2_MAX_LEN)) ? LW'(LOG2_MAX_LEN) : bus.Log2Len;
        change    = len_in != len_q;
        accept    = bus.InValid && !change;
        n         = FW'(1) << len_q;
        rd        = wr - LOG2_MAX_LEN'(n);
        fill_next = (fill == n) ? fill : fill + 1'b1;
        half      = ((SW+1)'(1) << len_q) >> 1;
        rnd       = {sum[SW-1], sum} + half;
    end

    // Sample RAM; contents survive reset, fill gating hides stale entries
    always_ff @(posedge Clk) begin
        if (Reset_n && accept) mem[wr] <= bus.Input;
    end

    // Stage 1: capture new and oldest sample, advance write pointer and fill count
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            wr    <= '0;
            fill  <= '0;
            len_q <= len_in;
            s1_v  <= 1'b0;
        end else if (change) begin
            len_q <= len_in;
            fill  <= '0;
            s1_v  <= 1'b0;
        end else begin
            s1_v <= bus.InValid;
            if (bus.InValid) begin
                wr      <= wr + 1'b1;
                fill    <= fill_next;
                s1_new  <= bus.Input;
                s1_old  <= mem[rd];
                s1_sub  <= fill == n;
                s1_full <= fill_next == n;
            end
        end
    end

    // Stage 2: running sum of the window, zero-padded until the window is full
    always_ff @(posedge Clk) begin
        if (!Reset_n || change) begin
            sum  <= '0;
            s2_v <= 1'b0;
        end else begin
            s2_v <= s1_v;
            if (s1_v) begin
                sum     <= sum + SW'(s1_new) - (s1_sub ? SW'(s1_old) : SW'(0));
                s2_full <= s1_full;
            end
        end
    end

    // Stage 3: rounded mean with status; Output and Settled hold between pulses
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            bus.Output   <= '0;
            bus.OutValid <= 1'b0;
            bus.Settled  <= 1'b0;
        end else if (change) begin
            bus.OutValid <= 1'b0;
        end else begin
            bus.OutValid <= s2_v;
            if (s2_v) begin
                bus.Output  <= DATA_WIDTH'(rnd >>> len_q);
                bus.Settled <= s2_full;
            end
        end
    end
endmodule

// File: tb/tb_moving_average_pow2.sv
// tb_moving_average_pow2: scoreboard bench with a window-history reference model
module tb_moving_average_pow2;
    typedef struct {
        int val;
        bit st;
        int e;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset_n;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   last_exp = 0;
    int   lq = 2;
    int   cur_len = 2;
    exp_t sbq[$];
    int   hist[$];

    moving_average_pow2_if #(.DATA_WIDTH(16), .LOG2_MAX_LEN(6)) bus ();
    moving_average_pow2 #(.LOG2_MAX_LEN(6), .DATA_WIDTH(16)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc++;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    // Reference: mean of the last N accepted samples since the last flush, zero padded
    task automatic model_cycle(input bit r, input bit v, input int d, input int l);
        int lc, ne, nw, s;
        exp_t x;
        lc = (l > 6) ? 6 : l;
        ne = cyc + 1;
        if (!r) begin
            sbq.delete();
            hist.delete();
            lq = lc;
        end else if (lc != lq) begin
            lq = lc;
            hist.delete();
            while (sbq.size() > 0 && sbq[$].e >= ne - 2) void'(sbq.pop_back());
        end else if (v) begin
            hist.push_back(d);
            if (hist.size() > 64) void'(hist.pop_front());
            nw = 1 << lq;
            s = 0;
            for (int i = 0; i < nw; i++) if (i < hist.size()) s += hist[hist.size() - 1 - i];
            x.val = (s + ((lq > 0) ? (1 << (lq - 1)) : 0)) >>> lq;
            x.st = hist.size() >= nw;
            x.e = ne;
            sbq.push_back(x);
        end
    endtask

    task automatic drive(input bit r, input bit v, input int d, input int l);
        @(negedge Clk);
        Reset_n = r;
        bus.InValid = v;
        bus.Input = 16'(d);
        bus.Log2Len = 3'(l);
        model_cycle(r, v, d, l);
    endtask

    // Monitor: checks reset state, pops on every OutValid, checks hold otherwise
    always @(posedge Clk) begin
        exp_t x;
        #1;
        if (!Reset_n) begin
            chk("rst_out", int'(bus.Output), 0);
            chk("rst_valid", int'(bus.OutValid), 0);
            chk("rst_settled", int'(bus.Settled), 0);
            last_exp = 0;
        end else if (bus.OutValid) begin
            if (sbq.size() == 0) begin
                chk("extra_pulse", int'(bus.Output), 99999);
            end else begin
                x = sbq.pop_front();
                chk("output", int'(bus.Output), x.val);
                chk("settled", int'(bus.Settled), int'(x.st));
                chk("latency", cyc - x.e, 2);
                last_exp = x.val;
            end
        end else begin
            chk("hold", int'(bus.Output), last_exp);
        end
    end

    initial begin
        Reset_n = 1'b0;
        bus.InValid = 1'b0;
        bus.Input = '0;
        bus.Log2Len = 3'd2;
        for (int i = 0; i < 3; i++) drive(0, 1, 1000, 2);
        for (int i = 0; i < 10; i++) drive(1, 1, 400, 2);
        drive(1, 0, 0, 1);
        drive(1, 1, -3, 1);
        drive(1, 1, -4, 1);
        drive(1, 1, -4, 1);
        for (int i = 0; i < 4; i++) drive(1, 0, 0, 1);
        drive(0, 1, 1000, 1);
        drive(1, 1, 3, 1);
        drive(1, 1, 4, 1);
        drive(1, 0, 0, 3);
        for (int k = 1; k <= 16; k++) begin
            drive(1, 1, 8 * k, 3);
            drive(1, 0, 0, 3);
            drive(1, 0, 0, 3);
        end
        drive(1, 0, 0, 2);
        for (int i = 0; i < 8; i++) drive(1, 1, 800, 2);
        for (int i = 0; i < 12; i++) drive(1, 1, 800, 3);
        for (int i = 0; i < 200; i++) drive(1, 1, 32767, 7);
        for (int i = 0; i < 200; i++) drive(1, 1, -32768, 7);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 29) == 0) cur_len = int'($urandom_range(0, 7));
            drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 65535)) - 32768, cur_len);
        end
        for (int i = 0; i < 10; i++) drive(1, 0, 0, cur_len);
        chk("drain", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/moving_average_pow2.md
# moving_average_pow2

Boxcar moving-average filter with a run-time selectable power-of-two window length. It sits directly downstream of the 5-tap moving-median despiker in the AverageAndMedian instrument. It takes the despiked signed 16-bit stream and produces a rounded running mean plus valid and window-full flags for the output/DAC path. A sample strobe lets it run at full clock rate or on a decimated stream.

## Interface
- LOG2_MAX_LEN, 6, log2 of the largest window; the buffer depth is 2^LOG2_MAX_LEN samples.
- DATA_WIDTH, 16, width of the signed sample.
- Clk  in  1  the single clock; all logic is on the rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- Input  in  DATA_WIDTH  signed sample (the median stage output).
- InValid  in  1  sample strobe; tie high for every-cycle operation.
- Log2Len  in  clog2(LOG2_MAX_LEN+1)  window length N = 2^L; values above LOG2_MAX_LEN clamp to LOG2_MAX_LEN.
- Output  out  DATA_WIDTH  signed rounded mean.
- OutValid  out  1  one-cycle pulse per accepted sample.
- Settled  out  1  high when the window holding Output contained N real samples.

## Operation
- State:
  - circular buffer of 2^LOG2_MAX_LEN samples;
  - write pointer wr, which wraps modulo the buffer depth;
  - fill counter, saturating at N;
  - latched length len_q;
  - accumulator sum, signed, DATA_WIDTH+LOG2_MAX_LEN bits.
- Accepted sample: InValid=1, Reset_n=1 and no length change in that cycle.
- On an accepted sample:
  - write it to buf[wr] and increment wr;
  - read the oldest sample as buf[(wr-N) mod depth];
  - if fill<N, the oldest sample counts as 0 (zero-padded start-up); otherwise it is the stored value;
  - sum <= sum + new - oldest;
  - fill <= min(fill+1, N).
- Output = (sum + 2^(L-1)) >>> L, arithmetic shift, rounding half toward +inf. For L=0 there is no rounding term and Output equals the sample.
  - The result always fits in DATA_WIDTH; no saturation logic is required.
- Settled is registered alongside Output. It is 1 when the fill count after that sample equals N.
- Length change: whenever the clamped Log2Len differs from len_q in a cycle, that cycle:
  - loads len_q;
  - clears sum and fill;
  - discards any sample presented in that cycle;
  - invalidates any in-flight pipeline sample, so no OutValid is produced for it.
  - wr and the buffer contents are left untouched; fill gating makes stale data invisible.
- Reset (Reset_n=0):
  - Output=0, OutValid=0, Settled=0;
  - sum=0, fill=0, wr=0, all pipeline valids cleared;
  - len_q loads the clamped Log2Len, so no spurious flush follows reset.
  - The buffer RAM is not cleared.
- Reset asserted mid-stream drops all in-flight results. The first post-reset output behaves exactly as after power-up.

## Timing
- Pipeline:
  - edge 1 registers the sample, the oldest value and the subtract-enable;
  - edge 2 updates sum;
  - edge 3 registers Output, OutValid and Settled.
- A sample accepted in cycle T gives OutValid=1 with its Output in cycle T+2.
- Throughput is one sample per clock. There is no backpressure, and InValid gaps of any length are allowed.
- Output holds its last value while OutValid=0.
- A length change in cycle C suppresses OutValid in cycles C+1 and C+2 for samples accepted in C-1 and C-2. The first new-length output can appear at C+3.
- Buffer wrap: reading (wr-N) across the depth boundary must be seamless, with no glitch when wr rolls over.

## Test plan
- Reset: Reset_n=0 for 3 cycles with InValid=1, Input=1000 -> Output=0, OutValid=0, Settled=0 throughout. After release, the first OutValid is exactly 2 cycles after the first accepted sample.
- Step fill: L=2, continuous Input=400 -> outputs 100, 200, 300, 400, 400…. Settled rises with the 4th output and stays high.
- Rounding: L=1, continuous inputs -3, -4, -4 -> outputs -1, -3 (-3.5 rounds up), -4. Also L=1 with inputs 3, 4 -> outputs 2, 4 (3.5 rounds to 4).
- Strobe gaps: L=3, InValid high one cycle in three, ramp 8, 16, …, 128 -> one output per strobe. After the window fills, each output equals the mean of the last 8 strobed samples; there are no extra pulses.
- Length change mid-stream: L=2 steady at 800, then L=3 -> the change-cycle sample and two in-flight results are dropped. Outputs then run 100, 200, …, 800; Settled stays low until the 8th post-change output.
- Extremes and clamp: Log2Len=7 (clamps to 6) with 200 samples of 32767 -> steady Output=32767. Then 200 samples of -32768 -> steady Output=-32768. No accumulator overflow, and outputs stay correct across multiple wr wrap-arounds.
